// File: rtl/ssenc_capture_if.sv
// Digit-in / frame-out handshake bundle for ssenc_capture.
// master = digit source and frame consumer side, slave = the capture block.
interface ssenc_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic                    seg_valid;
    logic                    seg_ready;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    value_valid;
    logic                    value_ready;
    logic                    err;
    logic [NUM_DIGITS-1:0]   blank_mask;

    modport master (
        output seg_in, seg_valid, value_ready,
        input  seg_ready, value, value_valid, err, blank_mask
    );

    modport slave (
        input  seg_in, seg_valid, value_ready,
        output seg_ready, value, value_valid, err, blank_mask
    );
endinterface

// File: rtl/ssenc_capture.sv
// Seven-segment pattern to nibble capture: assembles NUM_DIGITS digits (MSD first) into one frame.
// Optional SSENC_STRICT_BLANK_EN: a blank following a non-blank digit in the same frame sets err.
module ssenc_capture #(
    parameter int NUM_DIGITS = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               clear,
    ssenc_capture_if.slave     bus
);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [VW-1:0]         value_r;
    logic                  err_r;
    logic [NUM_DIGITS-1:0] blank_r;
    logic [3:0]            nib;
    logic                  dig_bad, dig_blank, dig_err, acc, last;

    // Returns {invalid, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'b0111111: decode = {2'b00, 4'h0};
            7'b0000110: decode = {2'b00, 4'h1};
            7'b1011011: decode = {2'b00, 4'h2};
            7'b1001111: decode = {2'b00, 4'h3};
            7'b1100110: decode = {2'b00, 4'h4};
            7'b1101101: decode = {2'b00, 4'h5};
            7'b1111101: decode = {2'b00, 4'h6};
            7'b0000111: decode = {2'b00, 4'h7};
            7'b1111111: decode = {2'b00, 4'h8};
            7'b1100111: decode = {2'b00, 4'h9};
            7'b1110111: decode = {2'b00, 4'hA};
            7'b1111100: decode = {2'b00, 4'hB};
            7'b0111001: decode = {2'b00, 4'hC};
            7'b1011110: decode = {2'b00, 4'hD};
            7'b1111001: decode = {2'b00, 4'hE};
            7'b1110001: decode = {2'b00, 4'hF};
            7'b0000000: decode = {2'b01, 4'h0};
            default:    decode = {2'b10, 4'h0};
        endcase
    endfunction

    assign {dig_bad, dig_blank, nib} = decode(bus.seg_in);
    assign acc  = bus.seg_valid & bus.seg_ready;
    assign last = (cnt == CW'(NUM_DIGITS - 1));

`ifdef SSENC_STRICT_BLANK_EN
    logic seen;

    // seen is only meaningful mid-frame; it is reloaded on every first digit
    assign dig_err = dig_bad | (dig_blank & seen & (state == COLLECT));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            seen <= 1'b0;
        else if (clear)
            seen <= 1'b0;
        else if (acc && state == IDLE)
            seen <= ~dig_blank;
        else if (acc)
            seen <= seen | ~dig_blank;
    end
`else
    assign dig_err = dig_bad;
`endif

    assign bus.seg_ready   = (state != DONE);
    assign bus.value_valid = (state == DONE);
    assign bus.value       = value_r;
    assign bus.err         = err_r;
    assign bus.blank_mask  = blank_r;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = last ? DONE : COLLECT;
            COLLECT: if (acc && last) state_nxt = DONE;
            DONE:    if (bus.value_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt     <= '0;
            value_r <= '0;
            err_r   <= 1'b0;
            blank_r <= '0;
        end else if (clear) begin
            cnt     <= '0;
            value_r <= '0;
            err_r   <= 1'b0;
            blank_r <= '0;
        end else if (acc && state == IDLE) begin
            cnt     <= CW'(1);
            value_r <= VW'(nib);
            err_r   <= dig_err;
            blank_r <= NUM_DIGITS'(dig_blank);
        end else if (acc) begin
            cnt     <= cnt + CW'(1);
            value_r <= (value_r << 4) | VW'(nib);
            err_r   <= err_r | dig_err;
            blank_r <= (blank_r << 1) | NUM_DIGITS'(dig_blank);
        end else if (state == DONE && bus.value_ready) begin
            cnt     <= '0;
        end
    end
endmodule

// File: tb/tb_ssenc_capture.sv
// Directed bench for ssenc_capture (NUM_DIGITS=4) with hand-computed frame results.
module tb_ssenc_capture;
    logic clk = 1'b0;
    logic nrst;
    logic clear;
    int   n_checks = 0;
    int   n_pass   = 0;

    ssenc_capture_if #(.NUM_DIGITS(4)) bus ();

    ssenc_capture #(.NUM_DIGITS(4)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011, S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110, S8 = 7'b1111111, S9 = 7'b1100111, SA = 7'b1110111;
    localparam logic [6:0] SB = 7'b1111100, SC = 7'b0111001, SD = 7'b1011110, SE = 7'b1111001;
    localparam logic [6:0] SF = 7'b1110001, BL = 7'b0000000, BAD = 7'b0000001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Called at a falling edge; presents one digit, waits for its accept, returns at the next falling edge.
    task automatic send_digit(input logic [6:0] p);
        int guard = 0;
        bus.seg_in    = p;
        bus.seg_valid = 1'b1;
        while (!bus.seg_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("rdy_timeout", 32'(bus.seg_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.seg_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
        send_digit(a);
        send_digit(b);
        send_digit(c);
        send_digit(d);
    endtask

    // Called at the falling edge right after the last accept.
    task automatic check_frame(input string tag, input logic [15:0] v, input logic e, input logic [3:0] bm);
        check({tag, "_vv"},    32'(bus.value_valid), 32'd1);
        check({tag, "_value"}, 32'(bus.value),       32'(v));
        check({tag, "_err"},   32'(bus.err),         32'(e));
        check({tag, "_blank"}, 32'(bus.blank_mask),  32'(bm));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_value"}, 32'(bus.value),       32'd0);
        check({tag, "_err"},   32'(bus.err),         32'd0);
        check({tag, "_blank"}, 32'(bus.blank_mask),  32'd0);
        check({tag, "_vv"},    32'(bus.value_valid), 32'd0);
        check({tag, "_rdy"},   32'(bus.seg_ready),   32'd1);
    endtask

    initial begin
        logic exp_strict_err;
`ifdef SSENC_STRICT_BLANK_EN
        exp_strict_err = 1'b1;
`else
        exp_strict_err = 1'b0;
`endif
        nrst            = 1'b0;
        clear           = 1'b0;
        bus.seg_in      = 7'd0;
        bus.seg_valid   = 1'b0;
        bus.value_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Plain frame, one-cycle value_valid pulse
        send_frame(S2, S1, SB, SF);
        check_frame("f1", 16'h21BF, 1'b0, 4'b0000);
        @(negedge clk);
        check("f1_vv_drop", 32'(bus.value_valid), 32'd0);
        check("f1_rdy_back", 32'(bus.seg_ready), 32'd1);
        check("f1_hold_value", 32'(bus.value), 32'h21BF);

        send_frame(BL, BL, S3, S0);
        check_frame("lead_blank", 16'h0030, 1'b0, 4'b1100);
        @(negedge clk);

        send_frame(S0, BL, S9, S1);
        check_frame("mid_blank", 16'h0091, exp_strict_err, 4'b0100);
        @(negedge clk);

        send_frame(S8, BAD, S8, S8);
        check_frame("invalid", 16'h8088, 1'b1, 4'b0000);
        @(negedge clk);
        send_frame(S2, S1, SB, SF);
        check_frame("clean_after_err", 16'h21BF, 1'b0, 4'b0000);
        @(negedge clk);

        // Back-pressure: DONE must absorb nothing
        bus.value_ready = 1'b0;
        send_frame(SE, SD, SC, SA);
        check_frame("bp", 16'hEDCA, 1'b0, 4'b0000);
        bus.seg_in    = S1;
        bus.seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rdy_low", 32'(bus.seg_ready), 32'd0);
            check("bp_value",   32'(bus.value),     32'hEDCA);
            check("bp_vv",      32'(bus.value_valid), 32'd1);
        end
        bus.value_ready = 1'b1;
        @(negedge clk);
        check("bp_release_vv",  32'(bus.value_valid), 32'd0);
        check("bp_release_rdy", 32'(bus.seg_ready),   32'd1);
        @(negedge clk);
        bus.seg_valid = 1'b0;
        check("fresh_first", 32'(bus.value), 32'h0001);
        send_digit(S2);
        send_digit(S3);
        send_digit(S4);
        check_frame("fresh_frame", 16'h1234, 1'b0, 4'b0000);
        @(negedge clk);

        // clear mid-frame overrides a simultaneous accept
        send_digit(BAD);
        send_digit(BL);
        check("pre_clear_err", 32'(bus.err), 32'd1);
        clear         = 1'b1;
        bus.seg_in    = S3;
        bus.seg_valid = 1'b1;
        @(negedge clk);
        clear         = 1'b0;
        bus.seg_valid = 1'b0;
        check_cleared("clear");
        send_frame(S2, S1, SB, SF);
        check_frame("after_clear", 16'h21BF, 1'b0, 4'b0000);
        @(negedge clk);

        // Asynchronous reset mid-frame
        send_digit(S8);
        send_digit(SB);
        #2 nrst = 1'b0;
        #1 check_cleared("async_rst");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        send_frame(SE, SD, SC, SA);
        check_frame("after_rst", 16'hEDCA, 1'b0, 4'b0000);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
